// File: rtl/mlp_deadlock_watchdog_if.sv
// ---------------------------------------------------------------------------
// mlp_deadlock_watchdog_if
// Bundles the command, MLP ap_* handshake and deadlock-monitor signals of the
// MLP run controller / deadlock watchdog.
//
//   cmd_valid   controller <- host  : request one MLP run
//   cmd_ready   controller -> host  : controller idle, command can be taken
//   thresh      controller <- host  : consecutive blocked cycles to declare deadlock
//   ap_start    controller -> MLP   : start
//   ap_idle     controller <- MLP   : idle flag
//   ap_done     controller <- MLP   : completion pulse
//   block_sigs  controller <- mons  : per-channel blocked flags
//   mlp_rst     controller -> MLP   : recovery reset, active-high
//   busy        controller -> host  : run or recovery in progress
//   done        controller -> host  : one-cycle normal completion pulse
//   deadlock    controller -> host  : one-cycle deadlock pulse
//   dl_src      controller -> host  : block_sigs captured at deadlock (sticky)
//   run_cycles  controller -> host  : cycle count of current/last run
//
// Modports: slave = watchdog side, master = host/MLP/monitor side.
// ---------------------------------------------------------------------------
interface mlp_deadlock_watchdog_if #(
    parameter int N_MON    = 3,
    parameter int THRESH_W = 16
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic [THRESH_W-1:0] thresh;
    logic                ap_start;
    logic                ap_idle;
    logic                ap_done;
    logic [N_MON-1:0]    block_sigs;
    logic                mlp_rst;
    logic                busy;
    logic                done;
    logic                deadlock;
    logic [N_MON-1:0]    dl_src;
    logic [31:0]         run_cycles;

    modport slave (
        input  cmd_valid, thresh, ap_idle, ap_done, block_sigs,
        output cmd_ready, ap_start, mlp_rst, busy, done, deadlock, dl_src, run_cycles
    );

    modport master (
        output cmd_valid, thresh, ap_idle, ap_done, block_sigs,
        input  cmd_ready, ap_start, mlp_rst, busy, done, deadlock, dl_src, run_cycles
    );
endinterface

// File: rtl/mlp_deadlock_watchdog.sv
// ---------------------------------------------------------------------------
// mlp_deadlock_watchdog
// Run controller and deadlock watchdog for the MLP HLS top. Launches one MLP
// invocation per accepted command (ap_start/ap_idle/ap_done), counts
// consecutive cycles with any monitor block flag set, and on reaching the
// programmed threshold pulses deadlock, latches the blocked channels and
// drives a RECOVER_CYCLES-long mlp_rst into the MLP before returning to idle.
//
// Ports:
//   i_clock  sole clock, rising edge
//   i_reset  synchronous, active-high reset
//   io_bus   mlp_deadlock_watchdog_if.slave (see interface file)
//
// Parameters: N_MON (monitor inputs), THRESH_W (threshold/counter width),
//             RECOVER_CYCLES (mlp_rst pulse length, >= 1).
//
// Optional feature: define MLP_WDOG_CYCLE_COUNT_EN to build the run_cycles
// counter; otherwise run_cycles is tied to zero.
// ---------------------------------------------------------------------------
module mlp_deadlock_watchdog #(
    parameter int N_MON          = 3,
    parameter int THRESH_W       = 16,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    mlp_deadlock_watchdog_if.slave        io_bus
);

    localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RECOVER
    } state_t;

    state_t              r_state;
    logic [THRESH_W-1:0] r_thr_q;
    logic [THRESH_W-1:0] r_blk_cnt;
    logic [REC_W-1:0]    r_rec_cnt;
    logic                r_cmd_ready;
    logic                r_ap_start;
    logic                r_mlp_rst;
    logic                r_busy;
    logic                r_done;
    logic                r_deadlock;
    logic [N_MON-1:0]    r_dl_src;

    state_t w_state_nxt;
    logic   w_accept;
    logic   w_done_nxt;
    logic   w_dl_nxt;
    logic   w_blocked;

    assign w_blocked = |io_bus.block_sigs;

    // Next-state decode. In RUN, ap_done is checked first so a completion
    // beats a deadlock detected in the same cycle.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        w_dl_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (io_bus.ap_done) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_blocked && (r_blk_cnt == r_thr_q - THRESH_W'(1))) begin
                    // This is the thr_q-th consecutive blocked cycle.
                    w_dl_nxt    = 1'b1;
                    w_state_nxt = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (r_rec_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs. Status outputs are decoded from the next
    // state so they line up with the state they describe.
    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_thr_q     <= THRESH_W'(1);
            r_blk_cnt   <= '0;
            r_rec_cnt   <= '0;
            r_cmd_ready <= 1'b1;
            r_ap_start  <= 1'b0;
            r_mlp_rst   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_deadlock  <= 1'b0;
            r_dl_src    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_mlp_rst   <= (w_state_nxt == S_RECOVER);
            r_done      <= w_done_nxt;
            r_deadlock  <= w_dl_nxt;

            if (w_accept) begin
                // A zero threshold behaves like a threshold of one.
                r_thr_q    <= (io_bus.thresh == '0) ? THRESH_W'(1) : io_bus.thresh;
                r_blk_cnt  <= '0;
                r_dl_src   <= '0;
                r_ap_start <= 1'b1;
            end else if (r_state == S_RUN) begin
                if (w_blocked) begin
                    if (r_blk_cnt != '1) begin
                        r_blk_cnt <= r_blk_cnt + THRESH_W'(1);
                    end
                end else begin
                    r_blk_cnt <= '0;
                end
                // ap_start is only ever set on accept, so once dropped it
                // stays low for the rest of the run.
                if (!io_bus.ap_idle || (w_state_nxt != S_RUN)) begin
                    r_ap_start <= 1'b0;
                end
                if (w_dl_nxt) begin
                    r_dl_src <= io_bus.block_sigs;
                end
            end

            if (w_dl_nxt) begin
                r_rec_cnt <= REC_W'(RECOVER_CYCLES - 1);
            end else if ((r_state == S_RECOVER) && (r_rec_cnt != '0)) begin
                r_rec_cnt <= r_rec_cnt - REC_W'(1);
            end
        end
    end

    assign io_bus.cmd_ready = r_cmd_ready;
    assign io_bus.ap_start  = r_ap_start;
    assign io_bus.mlp_rst   = r_mlp_rst;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.deadlock  = r_deadlock;
    assign io_bus.dl_src    = r_dl_src;

`ifdef MLP_WDOG_CYCLE_COUNT_EN
    logic [31:0] r_run_cycles;

    // Counts RUN cycles of the current run, saturating; holds after the run.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_run_cycles <= '0;
        end else if (w_accept) begin
            r_run_cycles <= '0;
        end else if ((r_state == S_RUN) && (r_run_cycles != '1)) begin
            r_run_cycles <= r_run_cycles + 32'd1;
        end
    end

    assign io_bus.run_cycles = r_run_cycles;
`else
    assign io_bus.run_cycles = '0;
`endif

endmodule

// File: tb/tb_mlp_deadlock_watchdog.sv
// ---------------------------------------------------------------------------
// tb_mlp_deadlock_watchdog
// Directed bench for mlp_deadlock_watchdog: a vector table covering reset, a
// normal run and a deadlock with recovery, followed by hand-written sequences
// for intermittent blocking, the done/deadlock tie, a zero threshold and
// reset during RUN and RECOVER. Inputs change on the falling edge; outputs
// are sampled 1 ns after the rising edge.
// Expected output word: {cmd_ready, ap_start, mlp_rst, busy, done, deadlock, dl_src}.
// ---------------------------------------------------------------------------
module tb_mlp_deadlock_watchdog;

    localparam int N_MON          = 3;
    localparam int THRESH_W       = 16;
    localparam int RECOVER_CYCLES = 4;

    logic clk;
    logic rst;

    mlp_deadlock_watchdog_if #(.N_MON(N_MON), .THRESH_W(THRESH_W)) bus ();

    mlp_deadlock_watchdog #(
        .N_MON          (N_MON),
        .THRESH_W       (THRESH_W),
        .RECOVER_CYCLES (RECOVER_CYCLES)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                rst;
        logic                cv;
        logic [THRESH_W-1:0] th;
        logic                idl;
        logic                dn;
        logic [N_MON-1:0]    blk;
        logic [8:0]          exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef MLP_WDOG_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.cmd_ready, bus.ap_start, bus.mlp_rst, bus.busy,
                bus.done, bus.deadlock, bus.dl_src};
    endfunction

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic add(input logic r, input logic cv, input logic [THRESH_W-1:0] th,
                       input logic idl, input logic dn, input logic [N_MON-1:0] blk,
                       input logic [8:0] exp);
        vecs.push_back('{r, cv, th, idl, dn, blk, exp});
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input logic r, input logic cv, input logic [THRESH_W-1:0] th,
                       input logic idl, input logic dn, input logic [N_MON-1:0] blk);
        @(negedge clk);
        rst            = r;
        bus.cmd_valid  = cv;
        bus.thresh     = th;
        bus.ap_idle    = idl;
        bus.ap_done    = dn;
        bus.block_sigs = blk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int dl_seen;
        int mrst_cnt;

        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.thresh     = '0;
        bus.ap_idle    = 1'b1;
        bus.ap_done    = 1'b0;
        bus.block_sigs = '0;

        // Reset, then normal run with thresh=8 (accept row 1).
        add(1, 0, 0, 1, 0, 3'b000, 9'b1_0_0_0_0_0_000);
        add(0, 1, 8, 1, 0, 3'b000, 9'b0_1_0_1_0_0_000);
        add(0, 0, 0, 1, 0, 3'b000, 9'b0_1_0_1_0_0_000);
        add(0, 0, 0, 0, 0, 3'b000, 9'b0_0_0_1_0_0_000);
        for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 0, 3'b000, 9'b0_0_0_1_0_0_000);
        add(0, 0, 0, 0, 1, 3'b000, 9'b1_0_0_0_1_0_000);
        add(0, 0, 0, 1, 0, 3'b000, 9'b1_0_0_0_0_0_000);
        // Deadlock with thresh=5, block 010 from RUN cycle 3 (rows 15..27).
        add(0, 1, 5, 1, 0, 3'b000, 9'b0_1_0_1_0_0_000);
        add(0, 0, 0, 0, 0, 3'b000, 9'b0_0_0_1_0_0_000);
        add(0, 0, 0, 0, 0, 3'b000, 9'b0_0_0_1_0_0_000);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 3'b010, 9'b0_0_0_1_0_0_000);
        add(0, 0, 0, 0, 0, 3'b010, 9'b0_0_1_1_0_1_010);
        add(0, 0, 0, 0, 1, 3'b010, 9'b0_0_1_1_0_0_010);
        add(0, 0, 0, 1, 0, 3'b000, 9'b0_0_1_1_0_0_010);
        add(0, 0, 0, 1, 0, 3'b000, 9'b0_0_1_1_0_0_010);
        add(0, 0, 0, 1, 0, 3'b000, 9'b1_0_0_0_0_0_010);
        add(0, 0, 0, 1, 0, 3'b000, 9'b1_0_0_0_0_0_010);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].cv, vecs[i].th, vecs[i].idl, vecs[i].dn, vecs[i].blk);
            check($sformatf("vec[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
            if (i == 14) check("normal_run_cycles", bus.run_cycles, exp_cnt(12));
        end
        check("dl_run_cycles", bus.run_cycles, exp_cnt(7));

        // Intermittent blocking with thresh=4: never 4 in a row.
        cyc(0, 1, 4, 1, 0, 3'b000);
        check("intm_accept", 32'(outs()), 32'(9'b0_1_0_1_0_0_000));
        dl_seen = 0;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) begin
                cyc(0, 0, 0, 0, 0, (p == 3) ? 3'b000 : 3'b001);
                dl_seen += int'(bus.deadlock);
            end
        end
        check("intm_no_deadlock", 32'(dl_seen), 32'd0);
        check("intm_busy", 32'(bus.busy), 32'd1);
        cyc(0, 0, 0, 0, 1, 3'b001);
        check("intm_done", 32'(outs()), 32'(9'b1_0_0_0_1_0_000));

        // Tie: ap_done on the 3rd blocked cycle with thresh=3.
        cyc(0, 1, 3, 1, 0, 3'b000);
        cyc(0, 0, 0, 0, 0, 3'b111);
        cyc(0, 0, 0, 0, 0, 3'b111);
        cyc(0, 0, 0, 0, 1, 3'b111);
        check("tie_done_wins", 32'(outs()), 32'(9'b1_0_0_0_1_0_000));
        check("tie_run_cycles", bus.run_cycles, exp_cnt(3));

        // thresh=0 acts as 1: a single blocked cycle deadlocks.
        cyc(0, 1, 0, 1, 0, 3'b000);
        cyc(0, 0, 0, 0, 0, 3'b100);
        check("th0_deadlock", 32'(outs()), 32'(9'b0_0_1_1_0_1_100));
        mrst_cnt = int'(bus.mlp_rst);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, 0, 3'b100);
            mrst_cnt += int'(bus.mlp_rst);
        end
        check("th0_mlp_rst_len", 32'(mrst_cnt), 32'(RECOVER_CYCLES));
        check("th0_back_idle", 32'(outs()), 32'(9'b1_0_0_0_0_0_100));

        // Reset mid-run, with ap_done coinciding: no done pulse.
        cyc(0, 1, 8, 1, 0, 3'b000);
        cyc(0, 0, 0, 0, 0, 3'b001);
        cyc(1, 0, 0, 0, 1, 3'b001);
        check("rst_run_outs", 32'(outs()), 32'(9'b1_0_0_0_0_0_000));
        check("rst_run_cycles", bus.run_cycles, 32'd0);
        cyc(0, 0, 0, 1, 0, 3'b000);
        check("rst_run_quiet", 32'(outs()), 32'(9'b1_0_0_0_0_0_000));
        cyc(0, 1, 2, 1, 0, 3'b000);
        check("rst_run_reaccept", 32'(outs()), 32'(9'b0_1_0_1_0_0_000));
        cyc(0, 0, 0, 0, 1, 3'b000);
        check("rst_run_redone", 32'(outs()), 32'(9'b1_0_0_0_1_0_000));

        // Reset mid-RECOVER.
        cyc(0, 1, 1, 1, 0, 3'b000);
        cyc(0, 0, 0, 0, 0, 3'b011);
        check("rst_rec_deadlock", 32'(outs()), 32'(9'b0_0_1_1_0_1_011));
        cyc(0, 0, 0, 1, 0, 3'b000);
        check("rst_rec_in_recover", 32'(outs()), 32'(9'b0_0_1_1_0_0_011));
        cyc(1, 0, 0, 1, 0, 3'b000);
        check("rst_rec_outs", 32'(outs()), 32'(9'b1_0_0_0_0_0_000));
        cyc(0, 0, 0, 1, 0, 3'b000);
        check("rst_rec_quiet", 32'(outs()), 32'(9'b1_0_0_0_0_0_000));
        cyc(0, 1, 6, 1, 0, 3'b000);
        check("rst_rec_reaccept", 32'(outs()), 32'(9'b0_1_0_1_0_0_000));
        cyc(0, 0, 0, 0, 1, 3'b000);
        check("rst_rec_redone", 32'(outs()), 32'(9'b1_0_0_0_1_0_000));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
